// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 LED-matrix scan engine fed from a sync-read frame buffer.
// Latency: one column per 1+2*CLK_DIV clks, rd_data sampled 1 clk after rd_en; row cost = shift + blank + latch + display.
// Backpressure: none; en is sampled only in IDLE and at row/plane boundaries, so a pass always completes.
// Build option: define HUB75_BCM_EN for CDEPTH-plane binary-code modulation (default: single MSB plane).
module hub75_scan_ctrl #(
    parameter int COLS    = 64,
    parameter int CDEPTH  = 4,
    parameter int CLK_DIV = 1,
    parameter int OE_BASE = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    output logic                    rd_en,
    output logic [$clog2(COLS)+3:0] rd_addr,
    input  logic [6*CDEPTH-1:0]     rd_data,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic                    D,
    output logic                    R0,
    output logic                    G0,
    output logic                    B0,
    output logic                    R1,
    output logic                    G1,
    output logic                    B1,
    output logic                    SCLK,
    output logic                    LAT,
    output logic                    OE,
    output logic                    frame_done
);

    localparam int COLW = $clog2(COLS);
    localparam int PW   = (CDEPTH > 1) ? $clog2(CDEPTH) : 1;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNTW = $clog2((OE_BASE << (CDEPTH - 1)) + 1);

    localparam logic [DIVW-1:0] DIV_LOAD = DIVW'(CLK_DIV - 1);
    localparam logic [COLW-1:0] COL_LAST = COLW'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_HIGH, S_BLANK, S_LATCH, S_DISPLAY
    } state_t;

    state_t            state_q;
    logic [3:0]        row_q;
    logic [COLW-1:0]   col_q;
    logic [DIVW-1:0]   div_q;
    logic [CNTW-1:0]   cnt_q;
    logic              first_q;
    logic [5:0]        rgb_q;
    logic              rd_en_q;
    logic [COLW+3:0]   addr_q;
    logic [3:0]        abcd_q;
    logic              sclk_q;
    logic              lat_q;
    logic              oe_q;
    logic              done_q;

`ifdef HUB75_BCM_EN
    logic [PW-1:0]     plane_q;
    wire               last_plane = (plane_q == PW'(CDEPTH - 1));
    wire  [PW-1:0]     bitsel     = plane_q;
    wire  [CNTW-1:0]   disp_load  = (CNTW'(OE_BASE) << plane_q) - CNTW'(1);
`else
    wire               last_plane = 1'b1;
    wire  [PW-1:0]     bitsel     = PW'(CDEPTH - 1);
    wire  [CNTW-1:0]   disp_load  = CNTW'(OE_BASE - 1);
`endif

    wire [3:0] row_nxt = last_plane ? row_q + 4'd1 : row_q;

    // Pick the active plane bit out of every channel field; rd_bits = {R0,G0,B0,R1,G1,B1}.
    wire [6*CDEPTH-1:0] rd_shift = rd_data >> bitsel;
    logic [5:0]         rd_bits;
    for (genvar j = 0; j < 6; j++) begin : g_ch
        assign rd_bits[j] = rd_shift[j*CDEPTH];
    end

    // Scan FSM: fetch/shift each column, blank, latch, then hold OE low for the plane weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
`ifdef HUB75_BCM_EN
            plane_q <= '0;
`endif
            first_q <= 1'b0;
            rgb_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            abcd_q  <= '0;
            sclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            oe_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    oe_q <= 1'b1;
                    if (en) begin
                        col_q   <= '0;
                        rd_en_q <= 1'b1;
                        addr_q  <= {row_q, COLW'(0)};
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    first_q <= 1'b1;
                    div_q   <= DIV_LOAD;
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    first_q <= 1'b0;
                    if (first_q) rgb_q <= rd_bits;
                    if (div_q == '0) begin
                        sclk_q  <= 1'b1;
                        div_q   <= DIV_LOAD;
                        state_q <= S_HIGH;
                    end else begin
                        div_q <= div_q - DIVW'(1);
                    end
                end
                S_HIGH: begin
                    if (div_q == '0) begin
                        sclk_q <= 1'b0;
                        col_q  <= col_q + COLW'(1);
                        if (col_q == COL_LAST) begin
                            state_q <= S_BLANK;
                        end else begin
                            rd_en_q <= 1'b1;
                            addr_q  <= {row_q, col_q + COLW'(1)};
                            state_q <= S_FETCH;
                        end
                    end else begin
                        div_q <= div_q - DIVW'(1);
                    end
                end
                S_BLANK: begin
                    abcd_q  <= row_q;
                    lat_q   <= 1'b1;
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    lat_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    cnt_q   <= disp_load;
                    state_q <= S_DISPLAY;
                end
                S_DISPLAY: begin
                    if (cnt_q == '0) begin
                        oe_q  <= 1'b1;
                        row_q <= row_nxt;
`ifdef HUB75_BCM_EN
                        plane_q <= last_plane ? '0 : plane_q + PW'(1);
`endif
                        if (last_plane && row_q == 4'hF) done_q <= 1'b1;
                        if (en) begin
                            rd_en_q <= 1'b1;
                            addr_q  <= {row_nxt, COLW'(0)};
                            state_q <= S_FETCH;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNTW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RAM data is only valid in the first SETUP cycle, so pass it straight through there
    // to give the panel a full SETUP period before SCLK rises; afterwards the copy holds it.
    wire [5:0] rgb_out = first_q ? rd_bits : rgb_q;

    assign {R0, G0, B0, R1, G1, B1} = rgb_out;
    assign {D, C, B, A}             = abcd_q;
    assign rd_en                    = rd_en_q;
    assign rd_addr                  = addr_q;
    assign SCLK                     = sclk_q;
    assign LAT                      = lat_q;
    assign OE                       = oe_q;
    assign frame_done               = done_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: COLS=4, CDEPTH=4, CLK_DIV=1, OE_BASE=8, RAM returns ram_f(addr).
// Expected column addresses/colours are queued when a pass is expected and compared against
// the observed SCLK/rd_en stream when the pass latches; timing of LAT/OE/frame_done checked inline.
module tb_hub75_scan_ctrl;

    localparam int COLS    = 4;
    localparam int CDEPTH  = 4;
    localparam int CLK_DIV = 1;
    localparam int OE_BASE = 8;
`ifdef HUB75_BCM_EN
    localparam int NP = CDEPTH;
`else
    localparam int NP = 1;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [23:0] rd_data;
    logic        A, B, C, D;
    logic        R0, G0, B0, R1, G1, B1;
    logic        SCLK, LAT, OE, frame_done;

    hub75_scan_ctrl #(
        .COLS(COLS), .CDEPTH(CDEPTH), .CLK_DIV(CLK_DIV), .OE_BASE(OE_BASE)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .SCLK(SCLK), .LAT(LAT), .OE(OE), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;
    int cur_row;
    int cur_plane;

    logic [5:0] exp_addr[$];
    logic [5:0] exp_rgb[$];
    logic [5:0] obs_addr[$];
    logic [5:0] obs_rgb[$];
    int         obs_rise[$];
    logic       sclk_prev = 1'b0;

    function automatic logic [23:0] ram_f(input logic [5:0] a);
        logic [31:0] t;
        t = {26'd0, a} * 32'h9E3779B1 + 32'h01234567;
        return t[31:8] ^ {4{a}};
    endfunction

    // Sync-read frame buffer model.
    initial rd_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= ram_f(rd_addr);
    end

    // Record what the DUT produces: fetch addresses, and colour + cycle at each SCLK rise.
    always @(negedge clk) begin
        if (rd_en === 1'b1) obs_addr.push_back(rd_addr);
        if (SCLK === 1'b1 && sclk_prev === 1'b0) begin
            obs_rgb.push_back({R0, G0, B0, R1, G1, B1});
            obs_rise.push_back(cyc);
        end
        sclk_prev = SCLK;
    end

    function automatic logic [31:0] outs();
        return {11'd0, rd_en, rd_addr, D, C, B, A, R0, G0, B0, R1, G1, B1, SCLK, LAT, OE, frame_done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic advance();
        cur_plane++;
        if (cur_plane == NP) begin
            cur_plane = 0;
            cur_row   = (cur_row + 1) % 16;
        end
    endtask

    // One row pass at (row, plane); drop=1 releases en when column 1 is fetched.
    task automatic run_pass(input int row, input int plane, input bit drop);
        logic [23:0] d;
        logic [5:0]  a;
        logic [3:0]  r0, g0, b0, r1, g1, b1;
        logic [5:0]  oa, orgb;
        int          b, lat_cyc, ocnt, rise[COLS];
        bit          got, oe_bad, last;
        b = (NP > 1) ? plane : CDEPTH - 1;
        for (int c = 0; c < COLS; c++) begin
            a = 6'(row * COLS + c);
            d = ram_f(a);
            {r0, g0, b0, r1, g1, b1} = d;
            exp_addr.push_back(a);
            exp_rgb.push_back({r0[b], g0[b], b0[b], r1[b], g1[b], b1[b]});
        end
        got = 1'b0; oe_bad = 1'b0; lat_cyc = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (drop && rd_en && rd_addr[1:0] == 2'd1) en = 1'b0;
            if (LAT === 1'b1) begin
                got = 1'b1;
                lat_cyc = cyc;
            end else if (OE !== 1'b1) begin
                oe_bad = 1'b1;
            end
        end
        check("lat_seen", got, 1);
        check("abcd_at_lat", {D, C, B, A}, row);
        check("oe_high_shift_latch", {oe_bad, OE}, 2'b01);
        for (int c = 0; c < COLS; c++) begin
            oa   = (obs_addr.size() > 0) ? obs_addr.pop_front() : 6'bx;
            orgb = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 6'bx;
            rise[c] = (obs_rise.size() > 0) ? obs_rise.pop_front() : -1000;
            check("rd_addr", oa, exp_addr.pop_front());
            check("rgb_at_sclk", orgb, exp_rgb.pop_front());
            if (c > 0) check("sclk_spacing", rise[c] - rise[c-1], 1 + 2 * CLK_DIV);
        end
        check("blank_then_lat", lat_cyc - rise[COLS-1], 2);
        @(negedge clk);
        check("lat_width", LAT, 0);
        ocnt = 0;
        while (OE === 1'b0 && ocnt < 1000) begin
            ocnt++;
            @(negedge clk);
        end
        check("oe_low_cycles", ocnt, OE_BASE << ((NP > 1) ? plane : 0));
        last = (row == 15 && plane == NP - 1);
        check("frame_done", frame_done, last);
        if (last) begin
            @(negedge clk);
            check("frame_done_width", frame_done, 0);
        end
    endtask

    initial begin
        bit bad;
        bit got;
        rst = 1'b0;
        en  = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_outputs", outs(), 32'h2);
        repeat (2) @(negedge clk);
        check("reset_hold", outs(), 32'h2);
        rst = 1'b0;
        @(negedge clk);
        check("idle_without_en", outs(), 32'h2);

        // Full frame plus the first pass after the wrap.
        en = 1'b1;
        cur_row = 0;
        cur_plane = 0;
        for (int n = 0; n < 16 * NP + 1; n++) begin
            run_pass(cur_row, cur_plane, 1'b0);
            advance();
        end
        while (!(cur_row == 3 && cur_plane == 0)) begin
            run_pass(cur_row, cur_plane, 1'b0);
            advance();
        end

        // Drop en during row 3 column 1: the plane finishes, then the engine idles.
        run_pass(cur_row, cur_plane, 1'b1);
        advance();
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_en !== 1'b0 || OE !== 1'b1) bad = 1'b1;
        end
        check("stopped_idle", bad, 0);

        // Restart resumes at the next plane/row.
        en = 1'b1;
        run_pass(cur_row, cur_plane, 1'b0);
        advance();

        // Asynchronous reset while SCLK is high.
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (SCLK === 1'b1) got = 1'b1;
        end
        check("high_seen", got, 1);
        rst = 1'b1;
        #1 check("reset_mid_high", outs(), 32'h2);
        @(negedge clk);
        check("reset_mid_hold", outs(), 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
